// File: rtl/reaction_timer_multi.sv
// Multi-round reaction timer: LFSR-randomised wait, stimulus, ms latency, best/average per session.
// All outputs registered, results one cycle after stop/timeout; no backpressure, unaccepted pulses are dropped.
module reaction_timer_multi #(
  parameter int CLKS_PER_MS  = 100_000,
  parameter int ROUNDS       = 4,
  parameter int MIN_DELAY_MS = 2000,
  parameter int DELAY_SPAN_W = 11,
  parameter int TIMEOUT_MS   = 1000,
  parameter int RES_W        = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      clear,
  output logic                      stimulus,
  output logic [RES_W-1:0]          result_ms,
  output logic                      result_valid,
  output logic [RES_W-1:0]          best_ms,
  output logic [RES_W-1:0]          avg_ms,
  output logic [$clog2(ROUNDS):0]   rounds_done,
  output logic                      cheat,
  output logic                      timeout,
  output logic                      done
);

  localparam int LOG2R   = $clog2(ROUNDS);
  localparam int RD_W    = LOG2R + 1;
  localparam int SUM_W   = RES_W + LOG2R;
  localparam int DLY_MAX = MIN_DELAY_MS + (1 << DELAY_SPAN_W) - 1;
  localparam int CNT_MAX = (DLY_MAX > TIMEOUT_MS) ? DLY_MAX : TIMEOUT_MS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PS_W    = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

  if (ROUNDS < 2 || (ROUNDS & (ROUNDS - 1)) != 0) begin : g_bad_rounds
    $error("ROUNDS must be a power of 2 and at least 2");
  end
  if (TIMEOUT_MS > (1 << RES_W) - 1) begin : g_bad_res_w
    $error("RES_W too narrow for TIMEOUT_MS");
  end

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_GO, S_RESULT, S_CHEAT, S_DONE} state_t;

  state_t             state;
  logic [15:0]        lfsr;
  logic [PS_W-1:0]    prescaler;
  logic [CNT_W-1:0]   ms_cnt;
  logic [CNT_W-1:0]   delay_ms;
  logic [SUM_W-1:0]   sum;

  logic               lfsr_fb;
  logic               tick;
  logic               go_stop;
  logic               go_tmo;
  logic               count_round;
  logic [RES_W-1:0]   round_res;
  logic [SUM_W-1:0]   sum_next;
  logic [RD_W-1:0]    rounds_next;

  assign lfsr_fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign tick        = (prescaler == PS_W'(CLKS_PER_MS - 1));
  assign go_stop     = (state == S_GO) && stop;
  // A stop landing on the final tick still counts as a real reaction.
  assign go_tmo      = (state == S_GO) && !stop && tick && (ms_cnt == CNT_W'(TIMEOUT_MS - 1));
  assign count_round = go_stop || go_tmo;
  assign round_res   = go_stop ? RES_W'(ms_cnt) : RES_W'(TIMEOUT_MS);
  assign sum_next    = sum + SUM_W'(round_res);
  assign rounds_next = rounds_done + RD_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr         <= 16'hACE1;
      state        <= S_IDLE;
      prescaler    <= '0;
      ms_cnt       <= '0;
      delay_ms     <= '0;
      sum          <= '0;
      stimulus     <= 1'b0;
      result_ms    <= '0;
      result_valid <= 1'b0;
      best_ms      <= '1;
      avg_ms       <= '0;
      rounds_done  <= '0;
      cheat        <= 1'b0;
      timeout      <= 1'b0;
      done         <= 1'b0;
    end else begin
      lfsr         <= {lfsr[14:0], lfsr_fb};
      result_valid <= 1'b0;
      prescaler    <= tick ? '0 : prescaler + PS_W'(1);
      if (clear) begin
        state       <= S_IDLE;
        prescaler   <= '0;
        ms_cnt      <= '0;
        delay_ms    <= '0;
        sum         <= '0;
        stimulus    <= 1'b0;
        result_ms   <= '0;
        best_ms     <= '1;
        avg_ms      <= '0;
        rounds_done <= '0;
        cheat       <= 1'b0;
        timeout     <= 1'b0;
        done        <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_RESULT, S_CHEAT, S_DONE: begin
            if (start) begin
              state     <= S_WAIT;
              prescaler <= '0;
              ms_cnt    <= '0;
              delay_ms  <= CNT_W'(MIN_DELAY_MS) + CNT_W'(lfsr[DELAY_SPAN_W-1:0]);
              cheat     <= 1'b0;
              timeout   <= 1'b0;
              done      <= 1'b0;
              if (state == S_DONE) begin
                sum         <= '0;
                best_ms     <= '1;
                rounds_done <= '0;
                result_ms   <= '0;
                avg_ms      <= '0;
              end
            end
          end
          S_WAIT: begin
            if (stop) begin
              state <= S_CHEAT;
              cheat <= 1'b1;
            end else if (tick) begin
              if (ms_cnt == delay_ms - CNT_W'(1)) begin
                state     <= S_GO;
                stimulus  <= 1'b1;
                prescaler <= '0;
                ms_cnt    <= '0;
              end else begin
                ms_cnt <= ms_cnt + CNT_W'(1);
              end
            end
          end
          S_GO: begin
            if (count_round) begin
              stimulus     <= 1'b0;
              result_ms    <= round_res;
              result_valid <= 1'b1;
              timeout      <= go_tmo;
              sum          <= sum_next;
              rounds_done  <= rounds_next;
              if (round_res < best_ms) best_ms <= round_res;
              if (rounds_next == RD_W'(ROUNDS)) begin
                state  <= S_DONE;
                done   <= 1'b1;
                avg_ms <= RES_W'(sum_next >> LOG2R);
              end else begin
                state <= S_RESULT;
              end
            end else if (tick) begin
              ms_cnt <= ms_cnt + CNT_W'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reaction_timer_multi.sv
// Self-checking bench for reaction_timer_multi: vector table, corner sequences, randomised sessions.
module tb_reaction_timer_multi;
  localparam int CLKS_PER_MS  = 4;
  localparam int ROUNDS       = 4;
  localparam int MIN_DELAY_MS = 3;
  localparam int DELAY_SPAN_W = 2;
  localparam int TIMEOUT_MS   = 10;
  localparam int RES_W        = 8;

  logic             clk = 1'b0;
  logic             rst, start, stop, clear;
  logic             stimulus, result_valid, cheat, timeout, done;
  logic [RES_W-1:0] result_ms, best_ms, avg_ms;
  logic [2:0]       rounds_done;
  logic [15:0]      m_lfsr;

  int n_cmp = 0;
  int n_err = 0;

  reaction_timer_multi #(
    .CLKS_PER_MS(CLKS_PER_MS), .ROUNDS(ROUNDS), .MIN_DELAY_MS(MIN_DELAY_MS),
    .DELAY_SPAN_W(DELAY_SPAN_W), .TIMEOUT_MS(TIMEOUT_MS), .RES_W(RES_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .stimulus(stimulus), .result_ms(result_ms), .result_valid(result_valid),
    .best_ms(best_ms), .avg_ms(avg_ms), .rounds_done(rounds_done),
    .cheat(cheat), .timeout(timeout), .done(done)
  );

  always #5 clk = ~clk;

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, free-running from reset.
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  typedef struct {
    int stop_k;
    int exp_res;
    int exp_tmo;
    int exp_best;
    int exp_rd;
    int exp_done;
    int exp_avg;
  } vec_t;

  vec_t vecs[4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_stimulus"}, int'(stimulus), 0);
    check({tag, "_result_ms"}, int'(result_ms), 0);
    check({tag, "_result_valid"}, int'(result_valid), 0);
    check({tag, "_best_ms"}, int'(best_ms), 255);
    check({tag, "_avg_ms"}, int'(avg_ms), 0);
    check({tag, "_rounds_done"}, int'(rounds_done), 0);
    check({tag, "_cheat"}, int'(cheat), 0);
    check({tag, "_timeout"}, int'(timeout), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  task automatic wait_go(input int exp_delay);
    int c;
    c = 0;
    while (stimulus !== 1'b1 && c < 200) begin
      step();
      c++;
    end
    check("wait_cycles", c, exp_delay * CLKS_PER_MS);
  endtask

  // Accept a start, check its side effects, then wait for the stimulus.
  task automatic start_wait(input int exp_rd);
    int d;
    d = MIN_DELAY_MS + int'(m_lfsr[DELAY_SPAN_W-1:0]);
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_rounds_done", int'(rounds_done), exp_rd);
    check("start_timeout_clr", int'(timeout), 0);
    check("start_cheat_clr", int'(cheat), 0);
    check("start_done_clr", int'(done), 0);
    wait_go(d);
  endtask

  // stop_k < 0 means no stop: let the round time out.
  task automatic finish_round(input int stop_k);
    if (stop_k >= 0) begin
      repeat (stop_k) step();
      stop = 1'b1;
      step();
      stop = 1'b0;
    end else begin
      repeat (TIMEOUT_MS * CLKS_PER_MS) step();
    end
    check("result_valid_pulse", int'(result_valid), 1);
    check("stimulus_off", int'(stimulus), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int q[$];
    int best_m, sum_m, k;

    vecs[0] = '{20,  5, 0, 5, 1, 0, 0};
    vecs[1] = '{29,  7, 0, 5, 2, 0, 0};
    vecs[2] = '{ 8,  2, 0, 2, 3, 0, 0};
    vecs[3] = '{-1, 10, 1, 2, 4, 1, 6};

    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
    repeat (2) step();
    check_reset("reset");
    rst = 1'b0;
    step();

    // Full session from the vector table: 5, 7, 2, timeout.
    for (int i = 0; i < 4; i++) begin
      start_wait(i);
      finish_round(vecs[i].stop_k);
      check("tbl_result_ms", int'(result_ms), vecs[i].exp_res);
      check("tbl_timeout", int'(timeout), vecs[i].exp_tmo);
      check("tbl_best_ms", int'(best_ms), vecs[i].exp_best);
      check("tbl_rounds_done", int'(rounds_done), vecs[i].exp_rd);
      check("tbl_done", int'(done), vecs[i].exp_done);
      check("tbl_avg_ms", int'(avg_ms), vecs[i].exp_avg);
      step();
      check("tbl_valid_drop", int'(result_valid), 0);
    end
    check("timeout_held", int'(timeout), 1);

    // New session from DONE, then an early press.
    start = 1'b1; step(); start = 1'b0;
    check("newsess_best", int'(best_ms), 255);
    check("newsess_result", int'(result_ms), 0);
    check("newsess_avg", int'(avg_ms), 0);
    check("newsess_timeout", int'(timeout), 0);
    step(); step();
    stop = 1'b1; step(); stop = 1'b0;
    check("cheat_set", int'(cheat), 1);
    check("cheat_rounds", int'(rounds_done), 0);
    seen = 0;
    repeat (40) begin
      step();
      if (stimulus === 1'b1) seen = 1;
    end
    check("cheat_no_stimulus", seen, 0);
    check("cheat_held", int'(cheat), 1);
    start = 1'b1; step(); start = 1'b0;
    check("retry_cheat_clr", int'(cheat), 0);
    step();
    stop = 1'b1; start = 1'b1; step(); stop = 1'b0; start = 1'b0;
    check("stop_start_cheat", int'(cheat), 1);
    check("stop_start_rounds", int'(rounds_done), 0);

    // Stop coinciding with the final GO tick wins.
    start_wait(0);
    finish_round(39);
    check("edge_result_ms", int'(result_ms), 9);
    check("edge_timeout", int'(timeout), 0);
    check("edge_rounds", int'(rounds_done), 1);
    check("edge_best", int'(best_ms), 9);

    // Asynchronous reset between edges during GO.
    start_wait(1);
    repeat (5) step();
    check("pre_rst_stimulus", int'(stimulus), 1);
    #3 rst = 1'b1;
    #1 check_reset("async_rst");
    #2 rst = 1'b0;
    step();

    // Synchronous clear during GO.
    start_wait(0);
    finish_round(13);
    check("pre_clear_result", int'(result_ms), 3);
    check("pre_clear_best", int'(best_ms), 3);
    start_wait(1);
    repeat (3) step();
    clear = 1'b1; step(); clear = 1'b0;
    check_reset("clear");
    seen = 0;
    repeat (50) begin
      step();
      if (stimulus === 1'b1) seen = 1;
    end
    check("clear_idle", seen, 0);

    // Randomised sessions against a list-based session model.
    for (int r = 0; r < 12; r++) begin
      if (q.size() == ROUNDS) q.delete();
      if ($urandom_range(0, 3) == 0) begin
        start = 1'b1; step(); start = 1'b0;
        repeat ($urandom_range(0, 10)) step();
        stop = 1'b1; step(); stop = 1'b0;
        check("rnd_cheat", int'(cheat), 1);
        check("rnd_cheat_rounds", int'(rounds_done), q.size());
        check("rnd_cheat_stim", int'(stimulus), 0);
      end
      start_wait(q.size());
      k = $urandom_range(0, 45);
      finish_round(k < 40 ? k : -1);
      q.push_back(k < 40 ? k / CLKS_PER_MS : TIMEOUT_MS);
      best_m = 255;
      sum_m = 0;
      foreach (q[j]) begin
        sum_m += q[j];
        if (q[j] < best_m) best_m = q[j];
      end
      check("rnd_result_ms", int'(result_ms), q[q.size()-1]);
      check("rnd_timeout", int'(timeout), (k >= 40) ? 1 : 0);
      check("rnd_best_ms", int'(best_ms), best_m);
      check("rnd_rounds_done", int'(rounds_done), q.size());
      check("rnd_done", int'(done), (q.size() == ROUNDS) ? 1 : 0);
      check("rnd_avg_ms", int'(avg_ms), (q.size() == ROUNDS) ? sum_m / ROUNDS : 0);
      step();
      check("rnd_valid_drop", int'(result_valid), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reaction_timer_multi.md
# reaction_timer_multi

Parametrised multi-round reaction timer core, the successor to the single-shot reaction timer. It generates an LFSR-randomised wait, raises a stimulus, and measures the stop latency in milliseconds. It flags early (cheat) presses and timeouts. Over a session of ROUNDS rounds it keeps the best time and the average time. It sits between the debounced button pulses and the seven-segment/LED display logic, and exposes binary results only; display formatting is done downstream.

## Interface
- CLKS_PER_MS, default 100_000: clk cycles per 1 ms tick (100 MHz board clock).
- ROUNDS, default 4: rounds per session. Must be a power of 2, at least 2; elaboration fails otherwise.
- MIN_DELAY_MS, default 2000: minimum random wait, in ms.
- DELAY_SPAN_W, default 11: random wait added on top of the minimum is 0..2^DELAY_SPAN_W-1 ms.
- TIMEOUT_MS, default 1000: reaction ceiling, in ms.
- RES_W, default 14: width of the result, best and average outputs. Must hold TIMEOUT_MS.

Ports:
- clk, in, 1: single system clock, rising edge.
- rst, in, 1: reset, asynchronous and active-high.
- start, in, 1: one-cycle pulse, already debounced and synchronised.
- stop, in, 1: one-cycle pulse, already debounced and synchronised.
- clear, in, 1: one-cycle pulse, synchronous session clear.
- stimulus, out, 1: reaction LED, high only in GO.
- result_ms, out, RES_W: last completed round time.
- result_valid, out, 1: one-cycle pulse when result_ms updates.
- best_ms, out, RES_W: minimum counted round time; all-ones means none yet.
- avg_ms, out, RES_W: session average, valid while done=1, otherwise 0.
- rounds_done, out, $clog2(ROUNDS)+1: number of rounds counted this session.
- cheat, out, 1: level, high in CHEAT state.
- timeout, out, 1: level, high from a timed-out round until the next start or clear.
- done, out, 1: level, high in DONE state.

## Operation
- States are IDLE, WAIT, GO, RESULT, CHEAT and DONE.
- Input priority: rst > clear > stop > start.
- LFSR:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11.
  - Reset seed 16'hACE1.
  - Steps every clk in all states.
- Delay: on entry to WAIT, delay_ms = MIN_DELAY_MS + lfsr[DELAY_SPAN_W-1:0] is latched.
- Tick generation:
  - The prescaler zeroes on entry to WAIT and on entry to GO.
  - tick is high when prescaler == CLKS_PER_MS-1.
  - ms_cnt also zeroes on entry to WAIT and on entry to GO.
- IDLE:
  - start goes to WAIT.
  - stop is ignored.
- WAIT:
  - stop goes to CHEAT. The round is not counted.
  - On a tick with ms_cnt == delay_ms-1, go to GO. Otherwise each tick increments ms_cnt.
- GO (stimulus=1):
  - stop: result_ms = ms_cnt, pulse result_valid, count the round.
  - On a tick with ms_cnt == TIMEOUT_MS-1: result_ms = TIMEOUT_MS, set timeout, pulse result_valid, count the round.
  - If stop and that tick happen in the same cycle, stop wins with TIMEOUT_MS-1.
- Counting a round:
  - sum += result. The sum is RES_W+$clog2(ROUNDS) bits and never overflows.
  - best_ms = min(best_ms, result).
  - rounds_done increments.
  - If the new rounds_done == ROUNDS, go to DONE; otherwise go to RESULT.
- RESULT:
  - start goes to WAIT (next round) and clears timeout.
- CHEAT:
  - start goes to WAIT and retries the same round; rounds_done is unchanged.
- DONE:
  - avg_ms = sum >> $clog2(ROUNDS), truncated.
  - start clears sum, best_ms (to all-ones), rounds_done, timeout and result_ms, then goes to WAIT.
- clear: from any state, synchronously returns every register to its reset value, then IDLE. LFSR is excluded and keeps running.

## Timing
- Reset values:
  - state IDLE, stimulus 0, result_ms 0, result_valid 0.
  - best_ms all-ones, avg_ms 0, rounds_done 0.
  - cheat 0, timeout 0, done 0.
  - LFSR 16'hACE1.
- All outputs are registered.
- start accepted at cycle N: state=WAIT at N+1.
- WAIT lasts exactly delay_ms*CLKS_PER_MS cycles; stimulus rises on the cycle after the final tick.
- stop at cycle M in GO:
  - result_ms and result_valid appear at M+1.
  - stimulus is 0 at M+1.
  - best_ms and rounds_done are updated at M+1.
  - avg_ms and done are valid at M+1 if that was the last round.
- rst asserted mid-round: all outputs go to reset values asynchronously, with no wait for a clk edge; no partial round is kept.
- start while in WAIT or GO: ignored.

## Test plan
Bench parameters: CLKS_PER_MS=4, ROUNDS=4, MIN_DELAY_MS=3, DELAY_SPAN_W=2, TIMEOUT_MS=10, RES_W=8.

- Single round, stop after 5 ticks in GO:
  - stimulus rises exactly (3+lfsr[1:0])*4 cycles after WAIT entry.
  - Next cycle: result_ms=5, result_valid pulses for 1 cycle, best_ms=5, rounds_done=1.
- Stop during WAIT:
  - cheat=1, rounds_done unchanged, stimulus never rises.
  - A following start re-enters WAIT with cheat=0.
- No stop in GO:
  - After 40 cycles in GO: result_ms=10, timeout=1.
  - The round is counted: rounds_done increments.
- Full session with rounds 5, 7, 2, 10 (timeout): done=1, best_ms=2, avg_ms=6 (24>>2), rounds_done=4.
- Simultaneous stop and start in WAIT: treated as cheat. Simultaneous stop and final tick in GO: result_ms=9, timeout=0.
- Mid-GO events:
  - rst asserted between clock edges during GO: outputs go to reset values immediately, with best_ms=8'hFF.
  - clear during GO: same values at the next edge, state IDLE.
